// File: rtl/ema_pkg.sv
// Shared encodings and fixed-point widths for the EMA trading pipeline.
package ema_pkg;

  localparam int unsigned QW    = 32;  // Q16.16 price width
  localparam int unsigned QFrac = 16;
  localparam int unsigned DiffW = QW + 1;
  localparam int unsigned ProdW = 41;

  typedef enum logic [1:0] {
    SigHold = 2'b00,
    SigBuy  = 2'b01,
    SigRsvd = 2'b10,
    SigSell = 2'b11
  } sig_e;

  typedef enum logic [1:0] {
    PosFlat  = 2'b00,
    PosLong  = 2'b01,
    PosShort = 2'b11
  } pos_e;

endpackage

// File: rtl/pnl_accum.sv
// Signed accumulator that clamps at the W-bit extremes instead of wrapping.
module pnl_accum #(
  parameter int unsigned W  = 48,
  parameter int unsigned AW = 41
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic signed [AW-1:0] addend_i,
  output logic signed [W-1:0]  acc_o
);

  // One spare bit above the wider operand keeps the raw sum exact.
  localparam int unsigned SW = ((W > AW) ? W : AW) + 1;
  localparam logic signed [SW-1:0] MaxV = (SW'(1) << (W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MinV = ~MaxV;

  logic signed [W-1:0]  acc_q, acc_d;
  logic signed [SW-1:0] sum;

  always_comb begin
    sum   = {{(SW - W){acc_q[W-1]}}, acc_q} + {{(SW - AW){addend_i[AW-1]}}, addend_i};
    acc_d = acc_q;
    if (en_i) begin
      if (sum > MaxV) begin
        acc_d = MaxV[W-1:0];
      end else if (sum < MinV) begin
        acc_d = MinV[W-1:0];
      end else begin
        acc_d = sum[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/position_manager.sv
// Turns BUY/SELL signals into single-slot orders, tracks the open position and realized PnL.
module position_manager
  import ema_pkg::*;
#(
  parameter int unsigned LOT   = 1,
  parameter int unsigned PNL_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_signal,
  input  logic [QW-1:0]    in_price,
  output logic             order_valid,
  input  logic             order_ready,
  output logic             order_side,
  output logic [8:0]       order_qty,
  output logic [QW-1:0]    order_price,
  output logic [1:0]       pos_state,
  output logic [QW-1:0]    entry_price,
  output logic [PNL_W-1:0] pnl,
  output logic [15:0]      drop_cnt
);

  localparam logic [7:0] LotV    = 8'(LOT);
  localparam logic [8:0] QtyOpen = 9'(LOT);
  localparam logic [8:0] QtyRev  = 9'(2 * LOT);

  logic            valid_q, valid_d;
  logic            side_q, side_d;
  logic [8:0]      qty_q, qty_d;
  logic [QW-1:0]   price_q, price_d;
  pos_e            pos_q, pos_d;
  logic [QW-1:0]   entry_q, entry_d;
  logic [15:0]     drop_q, drop_d;

  logic                    actionable, slot_free, accept, reversal;
  logic signed [DiffW-1:0] diff;
  logic signed [ProdW:0]   prod_full;
  logic signed [ProdW-1:0] prod;
  logic signed [PNL_W-1:0] pnl_acc;

  always_comb begin
    actionable = in_valid && (((in_signal == SigBuy) && (pos_q != PosLong)) ||
                              ((in_signal == SigSell) && (pos_q != PosShort)));
    slot_free  = !valid_q || order_ready;
    accept     = actionable && slot_free;
    reversal   = accept && (pos_q != PosFlat);

    valid_d = valid_q;
    side_d  = side_q;
    qty_d   = qty_q;
    price_d = price_q;
    pos_d   = pos_q;
    entry_d = entry_q;
    drop_d  = drop_q;

    if (accept) begin
      valid_d = 1'b1;
      side_d  = (in_signal == SigSell);
      qty_d   = (pos_q == PosFlat) ? QtyOpen : QtyRev;
      price_d = in_price;
      pos_d   = (in_signal == SigSell) ? PosShort : PosLong;
      entry_d = in_price;
    end else if (order_ready) begin
      valid_d = 1'b0;
    end

    if (actionable && !slot_free && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Closing a LONG profits when price rose; closing a SHORT profits when it fell.
  always_comb begin
    if (pos_q == PosLong) begin
      diff = $signed({1'b0, in_price}) - $signed({1'b0, entry_q});
    end else begin
      diff = $signed({1'b0, entry_q}) - $signed({1'b0, in_price});
    end
    prod_full = $signed({{(ProdW + 1 - DiffW){diff[DiffW-1]}}, diff}) *
                $signed({{(ProdW + 1 - 8){1'b0}}, LotV});
    prod      = prod_full[ProdW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      side_q  <= 1'b0;
      qty_q   <= '0;
      price_q <= '0;
      pos_q   <= PosFlat;
      entry_q <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      side_q  <= side_d;
      qty_q   <= qty_d;
      price_q <= price_d;
      pos_q   <= pos_d;
      entry_q <= entry_d;
      drop_q  <= drop_d;
    end
  end

  pnl_accum #(
    .W  (PNL_W),
    .AW (ProdW)
  ) u_pnl_accum (
    .clk      (clk),
    .rst      (rst),
    .en_i     (reversal),
    .addend_i (prod),
    .acc_o    (pnl_acc)
  );

  assign order_valid = valid_q;
  assign order_side  = side_q;
  assign order_qty   = qty_q;
  assign order_price = price_q;
  assign pos_state   = pos_q;
  assign entry_price = entry_q;
  assign pnl         = pnl_acc;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_position_manager.sv
// Directed bench: two instances (default, and LOT=255/PNL_W=42) checked every cycle against a model.
module tb_position_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_signal;
  logic [31:0] in_price;
  logic        order_ready;

  logic        ov0, sd0, ov1, sd1;
  logic [8:0]  qt0, qt1;
  logic [31:0] pr0, pr1, en0, en1;
  logic [1:0]  ps0, ps1;
  logic [47:0] pnl0;
  logic [41:0] pnl1;
  logic [15:0] dc0, dc1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  localparam logic [1:0] HOLD = 2'b00, BUY = 2'b01, RSV = 2'b10, SELL = 2'b11;

  always #5 clk = ~clk;

  position_manager u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_signal(in_signal), .in_price(in_price),
    .order_valid(ov0), .order_ready(order_ready), .order_side(sd0), .order_qty(qt0),
    .order_price(pr0), .pos_state(ps0), .entry_price(en0), .pnl(pnl0), .drop_cnt(dc0)
  );

  position_manager #(.LOT(255), .PNL_W(42)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_signal(in_signal), .in_price(in_price),
    .order_valid(ov1), .order_ready(order_ready), .order_side(sd1), .order_qty(qt1),
    .order_price(pr1), .pos_state(ps1), .entry_price(en1), .pnl(pnl1), .drop_cnt(dc1)
  );

  // Behavioural model: position as 0 flat / 1 long / 3 short, PnL as plain 64-bit integer.
  int          lot [2] = '{1, 255};
  int          pw  [2] = '{48, 42};
  bit          m_ov   [2];
  bit          m_side [2];
  int          m_qty  [2];
  longint      m_price[2];
  int          m_pos  [2];
  longint      m_entry[2];
  longint      m_pnl  [2];
  int          m_drop [2];

  function automatic longint clampw(longint v, int w);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_step(int i);
    bit     act, free;
    longint gain;
    act  = in_valid && ((in_signal == BUY && m_pos[i] != 1) || (in_signal == SELL && m_pos[i] != 3));
    free = !m_ov[i] || order_ready;
    if (act && free) begin
      m_ov[i]    = 1;
      m_side[i]  = (in_signal == SELL);
      m_qty[i]   = (m_pos[i] == 0) ? lot[i] : 2 * lot[i];
      m_price[i] = in_price;
      if (m_pos[i] != 0) begin
        gain = (m_pos[i] == 1) ? (longint'(in_price) - m_entry[i]) : (m_entry[i] - longint'(in_price));
        m_pnl[i] = clampw(m_pnl[i] + gain * lot[i], pw[i]);
      end
      m_pos[i]   = (in_signal == BUY) ? 1 : 3;
      m_entry[i] = in_price;
    end else if (act) begin
      if (m_drop[i] < 65535) m_drop[i]++;
    end else if (order_ready) begin
      m_ov[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_ov[i] = 0; m_side[i] = 0; m_qty[i] = 0; m_price[i] = 0;
        m_pos[i] = 0; m_entry[i] = 0; m_pnl[i] = 0; m_drop[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cmp(int i, logic ov, logic sd, logic [8:0] qt, logic [31:0] pr, logic [1:0] ps,
                     logic [31:0] en, logic [63:0] pn, logic [15:0] dc);
    logic [63:0] mask = (64'd1 << pw[i]) - 64'd1;
    chk($sformatf("d%0d.order_valid", i), ov, m_ov[i]);
    if (m_ov[i]) begin
      chk($sformatf("d%0d.order_side", i), sd, m_side[i]);
      chk($sformatf("d%0d.order_qty", i), qt, m_qty[i]);
      chk($sformatf("d%0d.order_price", i), pr, m_price[i]);
    end
    chk($sformatf("d%0d.pos_state", i), ps, m_pos[i]);
    chk($sformatf("d%0d.entry_price", i), en, m_entry[i]);
    chk($sformatf("d%0d.pnl", i), pn, m_pnl[i] & mask);
    chk($sformatf("d%0d.drop_cnt", i), dc, m_drop[i]);
  endtask

  always @(negedge clk) begin
    cmp(0, ov0, sd0, qt0, pr0, ps0, en0, {16'b0, pnl0}, dc0);
    cmp(1, ov1, sd1, qt1, pr1, ps1, en1, {22'b0, pnl1}, dc1);
  end

  task automatic cyc(logic v, logic [1:0] s, logic [31:0] p, logic r);
    in_valid = v; in_signal = s; in_price = p; order_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".valid"}, ov0, 0);
    chk({tag, ".side"}, sd0, 0);
    chk({tag, ".qty"}, qt0, 0);
    chk({tag, ".price"}, pr0, 0);
    chk({tag, ".pos"}, ps0, 0);
    chk({tag, ".entry"}, en0, 0);
    chk({tag, ".pnl0"}, pnl0, 0);
    chk({tag, ".drop"}, dc0, 0);
    chk({tag, ".pnl1"}, pnl1, 0);
  endtask

  initial begin
    rst = 1'b0;
    cyc(0, HOLD, 32'h0, 1);
    cyc(0, HOLD, 32'h0, 1);
    chk_zero("reset");
    rst = 1'b1;

    // Open long from flat
    cyc(1, BUY, 32'h0064_0000, 1);
    chk("open.valid", ov0, 1); chk("open.side", sd0, 0); chk("open.qty", qt0, 1);
    chk("open.price", pr0, 32'h0064_0000); chk("open.pos", ps0, 2'b01);
    chk("open.entry", en0, 32'h0064_0000); chk("open.pnl", pnl0, 0);
    chk("open.qty255", qt1, 255);

    // Reverse long->short at 105.0
    cyc(1, SELL, 32'h0069_0000, 1);
    chk("rev.side", sd0, 1); chk("rev.qty", qt0, 2); chk("rev.pos", ps0, 2'b11);
    chk("rev.entry", en0, 32'h0069_0000); chk("rev.pnl", pnl0, 48'h0000_0005_0000);
    chk("rev.pnl255", pnl1, 42'h000_04FB_0000);

    // Back to long at 100.0 (+5.0), then three SELLs against a stalled order
    cyc(1, BUY, 32'h0064_0000, 1);
    chk("rev2.pnl", pnl0, 48'h0000_000A_0000);
    for (int k = 0; k < 3; k++) cyc(1, SELL, 32'h006E_0000, 0);
    chk("stall.valid", ov0, 1); chk("stall.side", sd0, 0); chk("stall.qty", qt0, 2);
    chk("stall.price", pr0, 32'h0064_0000); chk("stall.drop", dc0, 3);
    chk("stall.pos", ps0, 2'b01);
    cyc(0, HOLD, 32'h0, 1);
    chk("retire.valid", ov0, 0);

    // Ready and new actionable signal in the same cycle
    cyc(1, SELL, 32'h0070_0000, 0);
    cyc(1, BUY, 32'h006A_0000, 1);
    chk("swap.valid", ov0, 1); chk("swap.side", sd0, 0); chk("swap.price", pr0, 32'h006A_0000);
    chk("swap.drop", dc0, 3); chk("swap.pnl", pnl0, 48'h0000_001C_0000);
    cyc(0, BUY, 32'h0001_0000, 1);
    chk("novalid.valid", ov0, 0);

    // Losing reversal: long at 106.0, sell at 80.0 -> 28 - 26 = 2.0
    cyc(1, SELL, 32'h0050_0000, 1);
    chk("loss.pnl", pnl0, 48'h0000_0002_0000);

    // Asynchronous reset mid-cycle with a pending order while short
    cyc(0, HOLD, 32'h0, 0);
    #3 rst = 1'b0;
    #1 chk_zero("areset");
    @(posedge clk); #1;
    rst = 1'b1;

    // First edge after release processes normally; then positive saturation (DUT1)
    cyc(1, BUY, 32'h0000_0000, 1);
    chk("release.valid", ov0, 1);
    cyc(1, SELL, 32'hFFFF_FFFF, 1);
    chk("sat1", pnl1, 42'h0FE_FFFF_FF01);
    cyc(1, BUY, 32'h0000_0000, 1);
    chk("sat2", pnl1, 42'h1FD_FFFF_FE02);
    cyc(1, SELL, 32'hFFFF_FFFF, 1);
    chk("sat3", pnl1, 42'h1FF_FFFF_FFFF);
    cyc(1, BUY, 32'h0000_0000, 1);
    chk("sat4", pnl1, 42'h1FF_FFFF_FFFF);

    // Now long: HOLD, reserved and duplicate BUY produce no order
    cyc(1, HOLD, 32'h0010_0000, 1);
    cyc(1, RSV, 32'h0010_0000, 1);
    cyc(1, BUY, 32'h0010_0000, 1);
    chk("ignore.valid", ov0, 0); chk("ignore.pos", ps0, 2'b01); chk("ignore.entry", en0, 0);

    // Negative saturation after a fresh reset
    cyc(0, HOLD, 32'h0, 1);
    rst = 1'b0;
    cyc(0, HOLD, 32'h0, 1);
    rst = 1'b1;
    cyc(1, BUY, 32'hFFFF_FFFF, 1);
    cyc(1, SELL, 32'h0000_0000, 1);
    chk("nsat1", pnl1, 42'h301_0000_00FF);
    cyc(1, BUY, 32'hFFFF_FFFF, 1);
    chk("nsat2", pnl1, 42'h202_0000_01FE);
    cyc(1, SELL, 32'h0000_0000, 1);
    chk("nsat3", pnl1, 42'h200_0000_0000);
    cyc(0, HOLD, 32'h0, 1);
    cyc(0, HOLD, 32'h0, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
